// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational 32-bit ALU among
// NUM_REQ requesters and returns each tagged result over a valid/ready channel.

module alu_core #(
  parameter int DATA_W = 32
) (
  input  logic        [1:0]        op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      2'b01:   result = a + b;
      2'b10:   result = a - b;
      2'b11:   result = a * b;
      default: result = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][1:0]            req_op,
  input  logic [NUM_REQ-1:0][31:0]           req_a,
  input  logic [NUM_REQ-1:0][31:0]           req_b,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         resp_id,
  output logic [31:0]                        resp_result,
  output logic                               busy
);

  localparam int IDW    = $clog2(NUM_REQ);
  localparam int DATA_W = 32;
  localparam int CNTW   = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                    state;
  logic [IDW-1:0]            rr_ptr;
  logic [CNTW-1:0]           cnt;

  logic        [1:0]         op_p0;
  logic signed [DATA_W-1:0]  a_p0;
  logic signed [DATA_W-1:0]  b_p0;
  logic        [IDW-1:0]     id_p0;
  logic signed [DATA_W-1:0]  alu_res;

  logic [NUM_REQ-1:0]        grant;
  logic [IDW-1:0]            grant_id;
  logic                      found;
  int                        idx;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [CNTW-1:0] op_latency(input logic [1:0] op);
    return (op == 2'b11) ? CNTW'(MUL_LAT) : CNTW'(1);
  endfunction

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .result (alu_res)
  );

  // Stage p0: operand capture at grant; the ALU only ever sees these.
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      op_p0 <= req_op[grant_id];
      a_p0  <= req_a[grant_id];
      b_p0  <= req_b[grant_id];
      id_p0 <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            cnt   <= op_latency(req_op[grant_id]);
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            resp_result <= alu_res;
            resp_id     <= id_p0;
            resp_valid  <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Priority only rotates once the consumer has taken the result.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= next_ptr(id_p0);
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a scoreboard of expected tagged results.

module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 2;

  logic                       clk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0][1:0]    req_op;
  logic [NUM_REQ-1:0][31:0]   req_a;
  logic [NUM_REQ-1:0][31:0]   req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [IDW-1:0]             resp_id;
  logic [31:0]                resp_result;
  logic                       busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    res;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      2'd3:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Walks from the grant cycle to the first response cycle, checking that
  // resp_valid stays low for L cycles and rises exactly on the next.
  task automatic run_lat(input int lat, input bit clr, input string tag);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == 1 && clr) req_valid = '0;
      at_neg();
      chk({tag, "_early_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    tick();
    at_neg();
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
  endtask

  // Scoreboard: push on every accepted request, pop on every response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back('{id: IDW'(i), res: model(req_op[i], req_a[i], req_b[i])});
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_resp_id", 32'(resp_id), 32'(e.id));
          chk("sb_resp_result", resp_result, e.res);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    at_neg();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Single ADD from requester 0.
    tick();
    set_req(0, 2'd1, 32'd5, 32'd7);
    at_neg();
    chk("add_grant", 32'(req_ready), 32'b0001);
    chk("add_idle_busy", 32'(busy), 32'd0);
    run_lat(1, 1'b1, "add");
    chk("add_id", 32'(resp_id), 32'd0);
    chk("add_result", resp_result, 32'd12);

    // MUL with low-32 wrap, then a plain product.
    tick();
    set_req(2, 2'd3, 32'h0001_0000, 32'h0001_0000);
    at_neg();
    chk("mul_wrap_grant", 32'(req_ready), 32'b0100);
    run_lat(MUL_LAT, 1'b1, "mul_wrap");
    chk("mul_wrap_result", resp_result, 32'd0);
    tick();
    set_req(3, 2'd3, 32'd6, 32'd7);
    at_neg();
    chk("mul_grant", 32'(req_ready), 32'b1000);
    run_lat(MUL_LAT, 1'b1, "mul");
    chk("mul_result", resp_result, 32'd42);

    // Round robin with every requester continuously valid.
    for (int n = 0; n < 5; n++) begin
      tick();
      if (n == 0)
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'd2, 32'd10, 32'(i));
      at_neg();
      chk("rr_grant", 32'(req_ready), 32'(1 << (n % NUM_REQ)));
      run_lat(1, 1'b0, "rr");
      chk("rr_result", resp_result, 32'd10 - 32'(n % NUM_REQ));
    end

    // Backpressure in DONE with another request pending.
    tick();
    req_valid  = '0;
    resp_ready = 1'b0;
    set_req(1, 2'd1, 32'd100, 32'd23);
    at_neg();
    chk("bp_grant", 32'(req_ready), 32'b0010);
    run_lat(1, 1'b1, "bp");
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) set_req(2, 2'd1, 32'd1, 32'd1);
      at_neg();
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_id", 32'(resp_id), 32'd1);
      chk("bp_hold_result", resp_result, 32'd123);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    tick();
    resp_ready = 1'b1;
    at_neg();
    chk("bp_done_no_grant", 32'(req_ready), 32'd0);
    tick();
    at_neg();
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    run_lat(1, 1'b1, "bp2");
    chk("bp2_result", resp_result, 32'd2);

    // SUB wrap and the zero opcode.
    tick();
    set_req(0, 2'd2, 32'd0, 32'd1);
    at_neg();
    chk("sub_grant", 32'(req_ready), 32'b0001);
    run_lat(1, 1'b1, "sub");
    chk("sub_result", resp_result, 32'hFFFF_FFFF);
    tick();
    set_req(1, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    at_neg();
    chk("zero_grant", 32'(req_ready), 32'b0010);
    run_lat(1, 1'b1, "zero");
    chk("zero_result", resp_result, 32'd0);

    // Reset while a MUL is in EXEC; the dropped op must never respond.
    tick();
    set_req(3, 2'd3, 32'd6, 32'd7);
    at_neg();
    chk("rmid_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    at_neg();
    chk("rmid_exec_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    sb.delete();
    at_neg();
    tick();
    rst = 1'b0;
    at_neg();
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rmid_req_ready", 32'(req_ready), 32'd0);
    tick();
    set_req(0, 2'd1, 32'd1, 32'd2);
    set_req(3, 2'd1, 32'd3, 32'd4);
    at_neg();
    chk("rmid_ptr_reset_grant", 32'(req_ready), 32'b0001);
    run_lat(1, 1'b1, "post_rst");
    chk("post_rst_result", resp_result, 32'd3);
    tick();
    at_neg();
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
